vga_crtc_registers: RTL and testbench

- Parametrised CRTC/status register block for the VGA controller, on the CPU data bus behind a chip select.
- Provides an indexed CRTC register file, plus mode and colour-select registers and a status register with a sticky retrace flag.
- Cursor and start-address outputs are double-buffered. They transfer to the display side only at vertical-retrace start, so the picture never tears mid-frame.

---
 rtl/vga_pkg.sv | 36 +++
 rtl/vga_retrace_detect.sv | 37 +++
 rtl/vga_crtc_registers.sv | 176 +++++++++++++++++
 tb/tb_vga_crtc_registers.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and types for the VGA CRTC register block.
//   - Bus offsets (word address bits [3:1]) of the index/data, mode/colour
//     and status registers.
//   - Indices of the implemented CRTC registers.
//   - crtc_shadow_t: every field that is double-buffered to the display side.
//     Address fields are sized for the widest supported VADDR_W (16).
//   - status_byte(): assembles the status register read value.
package vga_pkg;

  localparam logic [2:0] OFF_INDEX  = 3'b010;
  localparam logic [2:0] OFF_MODE   = 3'b011;
  localparam logic [2:0] OFF_STATUS = 3'b101;

  localparam int CRTC_CURSOR_START = 'hA;
  localparam int CRTC_CURSOR_END   = 'hB;
  localparam int CRTC_START_HI     = 'hC;
  localparam int CRTC_START_LO     = 'hD;
  localparam int CRTC_CURSOR_HI    = 'hE;
  localparam int CRTC_CURSOR_LO    = 'hF;

  typedef struct packed {
    logic [15:0] cursor_pos;
    logic [15:0] start_addr;
    logic [4:0]  cursor_start;
    logic [4:0]  cursor_end;
    logic        cursor_disable;
  } crtc_shadow_t;

  // bit0: in any retrace, bit3: in vertical retrace, bit7: sticky retrace flag
  function automatic logic [7:0] status_byte(input logic hsync_n,
                                             input logic vsync_n,
                                             input logic pending);
    return {pending, 3'b000, ~vsync_n, 2'b00, ~hsync_n | ~vsync_n};
  endfunction

endpackage

// File: rtl/vga_retrace_detect.sv
// vga_retrace_detect: vertical-retrace start detector and sticky flag.
//   i_clk, i_reset        : clock, synchronous active-high reset
//   i_vsync               : active-low vertical sync (clk domain)
//   i_status_rd           : status register read in progress (clears flag)
//   o_retrace_start       : combinational, high in the cycle vsync falls
//   o_retrace_pending     : sticky flag, set at retrace start
module vga_retrace_detect (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_vsync,
  input  logic i_status_rd,
  output logic o_retrace_start,
  output logic o_retrace_pending
);

  logic r_vsync_q;
  logic r_pending;

  assign o_retrace_start   = r_vsync_q & ~i_vsync;
  assign o_retrace_pending = r_pending;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      // Idle level, so a low vsync coming out of reset still counts as an edge
      r_vsync_q <= 1'b1;
      r_pending <= 1'b0;
    end else begin
      r_vsync_q <= i_vsync;
      // A new retrace beats a simultaneous clearing read
      if (o_retrace_start)
        r_pending <= 1'b1;
      else if (i_status_rd)
        r_pending <= 1'b0;
    end
  end

endmodule

// File: rtl/vga_crtc_registers.sv
// vga_crtc_registers: CPU-visible CRTC/mode/colour/status registers of the
// VGA controller.
//   Bus side : cs, data_m_addr[19:1] (only [3:1] decoded), data_m_data_in,
//              data_m_bytesel, data_m_wr_en, data_m_access -> data_m_ack and
//              registered data_m_data_out (one cycle after the access).
//   Display  : vga_vsync/vga_hsync in (active low); cursor_pos, cursor_start,
//              cursor_end, cursor_disable and start_addr are shadow copies
//              updated only at vertical-retrace start; mode_reg, colour_reg
//              are live.
//   vga_irq  : retrace interrupt, present only when VGA_IRQ_EN is defined;
//              otherwise tied low and mode_reg[6] is plain storage.
module vga_crtc_registers
  import vga_pkg::*;
#(
  parameter int NUM_CRTC_REGS = 32,
  parameter int VADDR_W       = 14
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cs,
  input  logic [19:1]        data_m_addr,
  input  logic [15:0]        data_m_data_in,
  output logic [15:0]        data_m_data_out,
  input  logic [1:0]         data_m_bytesel,
  input  logic               data_m_wr_en,
  input  logic               data_m_access,
  output logic               data_m_ack,
  input  logic               vga_vsync,
  input  logic               vga_hsync,
  output logic [VADDR_W-1:0] cursor_pos,
  output logic [4:0]         cursor_start,
  output logic [4:0]         cursor_end,
  output logic               cursor_disable,
  output logic [VADDR_W-1:0] start_addr,
  output logic [7:0]         mode_reg,
  output logic [7:0]         colour_reg,
  output logic               vga_irq
);

  localparam int IDX_W = $clog2(NUM_CRTC_REGS);
  localparam int HI_W  = VADDR_W - 8;

  localparam logic [IDX_W-1:0] IDX_CSTART = IDX_W'(CRTC_CURSOR_START);
  localparam logic [IDX_W-1:0] IDX_CEND   = IDX_W'(CRTC_CURSOR_END);
  localparam logic [IDX_W-1:0] IDX_SHI    = IDX_W'(CRTC_START_HI);
  localparam logic [IDX_W-1:0] IDX_SLO    = IDX_W'(CRTC_START_LO);
  localparam logic [IDX_W-1:0] IDX_CHI    = IDX_W'(CRTC_CURSOR_HI);
  localparam logic [IDX_W-1:0] IDX_CLO    = IDX_W'(CRTC_CURSOR_LO);
  // Keeps unused high-address bits zero so readback and shadows agree
  localparam logic [7:0]       HI_MASK    = 8'((1 << HI_W) - 1);

  logic             w_acc, w_rd, w_wr;
  logic [2:0]       w_off;
  logic             w_wr_index, w_wr_data, w_status_rd;
  logic [IDX_W-1:0] w_idx;
  logic [7:0]       w_din_lo, w_din_hi, w_crtc_rd;
  logic [15:0]      w_rd_data;
  logic             w_retrace_start, w_pending;

  logic [IDX_W-1:0] r_index;
  logic [7:0]       r_mode, r_colour;
  logic [15:0]      r_data_out;
  logic             r_ack, r_irq;
  crtc_shadow_t     r_live, r_shadow;

  assign w_acc       = cs & data_m_access;
  assign w_rd        = w_acc & ~data_m_wr_en;
  assign w_wr        = w_acc & data_m_wr_en;
  assign w_off       = data_m_addr[3:1];
  assign w_din_lo    = data_m_data_in[7:0];
  assign w_din_hi    = data_m_data_in[15:8];
  assign w_wr_index  = w_wr & (w_off == OFF_INDEX) & data_m_bytesel[0];
  assign w_wr_data   = w_wr & (w_off == OFF_INDEX) & data_m_bytesel[1];
  assign w_status_rd = w_rd & (w_off == OFF_STATUS);
  // A data write sharing the cycle with an index write targets the new index
  assign w_idx       = w_wr_index ? w_din_lo[IDX_W-1:0] : r_index;

  vga_retrace_detect u_retrace (
    .i_clk             (clk),
    .i_reset           (reset),
    .i_vsync           (vga_vsync),
    .i_status_rd       (w_status_rd),
    .o_retrace_start   (w_retrace_start),
    .o_retrace_pending (w_pending)
  );

  always_comb begin
    w_crtc_rd = '0;
    case (r_index)
      IDX_CSTART: w_crtc_rd = {2'b00, r_live.cursor_disable, r_live.cursor_start};
      IDX_CEND:   w_crtc_rd = {3'b000, r_live.cursor_end};
      IDX_SHI:    w_crtc_rd = r_live.start_addr[15:8];
      IDX_SLO:    w_crtc_rd = r_live.start_addr[7:0];
      IDX_CHI:    w_crtc_rd = r_live.cursor_pos[15:8];
      IDX_CLO:    w_crtc_rd = r_live.cursor_pos[7:0];
      default:    w_crtc_rd = '0;
    endcase
  end

  always_comb begin
    w_rd_data = '0;
    if (w_rd) begin
      case (w_off)
        OFF_INDEX: begin
          if (data_m_bytesel[0]) w_rd_data[7:0]  = 8'(r_index);
          if (data_m_bytesel[1]) w_rd_data[15:8] = w_crtc_rd;
        end
        OFF_MODE: begin
          if (data_m_bytesel[0]) w_rd_data[7:0]  = r_mode;
          if (data_m_bytesel[1]) w_rd_data[15:8] = r_colour;
        end
        OFF_STATUS: begin
          if (data_m_bytesel[0])
            w_rd_data[7:0] = status_byte(vga_hsync, vga_vsync, w_pending);
        end
        default: w_rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_index    <= '0;
      r_mode     <= '0;
      r_colour   <= '0;
      r_data_out <= '0;
      r_ack      <= 1'b0;
      r_irq      <= 1'b0;
      r_live     <= '0;
      r_shadow   <= '0;
    end else begin
      r_ack      <= w_acc;
      r_data_out <= w_rd_data;
      // Captures pre-write live values; a same-cycle write waits a frame
      if (w_retrace_start)
        r_shadow <= r_live;
      if (w_wr_index)
        r_index <= w_din_lo[IDX_W-1:0];
      if (w_wr_data) begin
        case (w_idx)
          IDX_CSTART: begin
            r_live.cursor_disable <= w_din_hi[5];
            r_live.cursor_start   <= w_din_hi[4:0];
          end
          IDX_CEND: r_live.cursor_end        <= w_din_hi[4:0];
          IDX_SHI:  r_live.start_addr[15:8]  <= w_din_hi & HI_MASK;
          IDX_SLO:  r_live.start_addr[7:0]   <= w_din_hi;
          IDX_CHI:  r_live.cursor_pos[15:8]  <= w_din_hi & HI_MASK;
          IDX_CLO:  r_live.cursor_pos[7:0]   <= w_din_hi;
          default: ;
        endcase
      end
      if (w_wr && (w_off == OFF_MODE)) begin
        if (data_m_bytesel[0]) r_mode   <= w_din_lo;
        if (data_m_bytesel[1]) r_colour <= w_din_hi;
      end
`ifdef VGA_IRQ_EN
      r_irq <= w_pending & r_mode[6];
`else
      r_irq <= 1'b0;
`endif
    end
  end

  assign data_m_data_out = r_data_out;
  assign data_m_ack      = r_ack;
  assign cursor_pos      = r_shadow.cursor_pos[VADDR_W-1:0];
  assign start_addr      = r_shadow.start_addr[VADDR_W-1:0];
  assign cursor_start    = r_shadow.cursor_start;
  assign cursor_end      = r_shadow.cursor_end;
  assign cursor_disable  = r_shadow.cursor_disable;
  assign mode_reg        = r_mode;
  assign colour_reg      = r_colour;
  assign vga_irq         = r_irq;

endmodule

// File: tb/tb_vga_crtc_registers.sv
module tb_vga_crtc_registers;
  import vga_pkg::*;

  localparam int VADDR_W = 14;

  logic               clk = 1'b0;
  logic               reset;
  logic               cs;
  logic [19:1]        data_m_addr;
  logic [15:0]        data_m_data_in;
  logic [15:0]        data_m_data_out;
  logic [1:0]         data_m_bytesel;
  logic               data_m_wr_en;
  logic               data_m_access;
  logic               data_m_ack;
  logic               vga_vsync;
  logic               vga_hsync;
  logic [VADDR_W-1:0] cursor_pos;
  logic [4:0]         cursor_start;
  logic [4:0]         cursor_end;
  logic               cursor_disable;
  logic [VADDR_W-1:0] start_addr;
  logic [7:0]         mode_reg;
  logic [7:0]         colour_reg;
  logic               vga_irq;

  vga_crtc_registers #(.NUM_CRTC_REGS(32), .VADDR_W(VADDR_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .cs              (cs),
    .data_m_addr     (data_m_addr),
    .data_m_data_in  (data_m_data_in),
    .data_m_data_out (data_m_data_out),
    .data_m_bytesel  (data_m_bytesel),
    .data_m_wr_en    (data_m_wr_en),
    .data_m_access   (data_m_access),
    .data_m_ack      (data_m_ack),
    .vga_vsync       (vga_vsync),
    .vga_hsync       (vga_hsync),
    .cursor_pos      (cursor_pos),
    .cursor_start    (cursor_start),
    .cursor_end      (cursor_end),
    .cursor_disable  (cursor_disable),
    .start_addr      (start_addr),
    .mode_reg        (mode_reg),
    .colour_reg      (colour_reg),
    .vga_irq         (vga_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cs, acc, wr;
    logic [2:0]  off;
    logic [1:0]  sel;
    logic [15:0] d;
    logic        vs, hs;
    logic [15:0] exp;
  } op_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [16:0] sb[$];   // {expected ack, expected data_out}

  function automatic op_t W(input logic [2:0] off, input logic [1:0] sel,
                            input logic [15:0] d, input logic vs = 1'b1);
    op_t o;
    o.cs = 1'b1; o.acc = 1'b1; o.wr = 1'b1; o.off = off; o.sel = sel;
    o.d = d; o.vs = vs; o.hs = 1'b1; o.exp = 16'h0;
    return o;
  endfunction

  function automatic op_t R(input logic [2:0] off, input logic [1:0] sel,
                            input logic [15:0] exp, input logic vs = 1'b1,
                            input logic hs = 1'b1);
    op_t o;
    o.cs = 1'b1; o.acc = 1'b1; o.wr = 1'b0; o.off = off; o.sel = sel;
    o.d = 16'($urandom); o.vs = vs; o.hs = hs; o.exp = exp;
    return o;
  endfunction

  function automatic op_t IDL(input logic vs = 1'b1);
    op_t o;
    o.cs = 1'b1; o.acc = 1'b0; o.wr = 1'b0; o.off = 3'($urandom); o.sel = 2'b11;
    o.d = 16'($urandom); o.vs = vs; o.hs = 1'b1; o.exp = 16'h0;
    return o;
  endfunction

  // Chip select low while the bus cycle is valid: must be ignored entirely
  function automatic op_t NOCS(input logic wr, input logic [2:0] off, input logic [15:0] d);
    op_t o;
    o.cs = 1'b0; o.acc = 1'b1; o.wr = wr; o.off = off; o.sel = 2'b11;
    o.d = d; o.vs = 1'b1; o.hs = 1'b1; o.exp = 16'h0;
    return o;
  endfunction

  // Drives one bus cycle, records what the DUT owes for it, returns #1 after the edge
  task automatic apply(input op_t o);
    @(negedge clk);
    cs             = o.cs;
    data_m_access  = o.acc;
    data_m_wr_en   = o.wr;
    data_m_addr    = {16'($urandom), o.off};
    data_m_bytesel = o.sel;
    data_m_data_in = o.d;
    vga_vsync      = o.vs;
    vga_hsync      = o.hs;
    sb.push_back({o.cs & o.acc, (o.cs & o.acc & ~o.wr) ? o.exp : 16'h0});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; cs = 1'b0; data_m_access = 1'b0; data_m_wr_en = 1'b0;
    vga_vsync = 1'b1; vga_hsync = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    op_t ops[$];
    logic [16:0] got, exp;
    do_reset();
    n_checks++;
    if ({data_m_ack, data_m_data_out} !== 17'h0) begin
      n_errors++;
      $display("FAIL reset_bus: ack/data=%b/%h required 0/0000", data_m_ack, data_m_data_out);
    end
    n_checks++;
    if ({cursor_pos, start_addr, cursor_start, cursor_end, cursor_disable} !== '0) begin
      n_errors++;
      $display("FAIL reset_shadow: cpos=%h saddr=%h cs=%h ce=%h cd=%b required all 0",
               cursor_pos, start_addr, cursor_start, cursor_end, cursor_disable);
    end
    n_checks++;
    if ({mode_reg, colour_reg, vga_irq} !== 17'h0) begin
      n_errors++;
      $display("FAIL reset_live: mode=%h colour=%h irq=%b required 0", mode_reg, colour_reg, vga_irq);
    end
    ops = '{R(OFF_STATUS, 2'b01, 16'h0000), R(OFF_INDEX, 2'b11, 16'h0000),
            R(OFF_MODE, 2'b11, 16'h0000), IDL()};
    foreach (ops[i]) begin
      apply(ops[i]);
      got = {data_m_ack, data_m_data_out}; exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL reset_rd[%0d]: ack/data=%b/%h required %b/%h", i, got[16], got[15:0], exp[16], exp[15:0]);
      end
    end
  endtask

  task automatic test_cursor();
    op_t ops[$];
    logic [16:0] got, exp;
    do_reset();
    ops = '{W(OFF_INDEX, 2'b01, 16'h000E), W(OFF_INDEX, 2'b10, 16'h1200),
            W(OFF_INDEX, 2'b01, 16'h000F), W(OFF_INDEX, 2'b10, 16'h3400),
            R(OFF_INDEX, 2'b10, 16'h3400), R(OFF_INDEX, 2'b11, 16'h340F),
            W(OFF_INDEX, 2'b11, 16'h2B0A), R(OFF_INDEX, 2'b11, 16'h2B0A),
            W(OFF_INDEX, 2'b11, 16'hFF0B), R(OFF_INDEX, 2'b11, 16'h1F0B),
            W(OFF_INDEX, 2'b11, 16'hFF0A), R(OFF_INDEX, 2'b11, 16'h3F0A),
            W(OFF_INDEX, 2'b11, 16'h2B0A), IDL()};
    foreach (ops[i]) begin
      apply(ops[i]);
      got = {data_m_ack, data_m_data_out}; exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL cursor_bus[%0d]: ack/data=%b/%h required %b/%h", i, got[16], got[15:0], exp[16], exp[15:0]);
      end
    end
    n_checks++;
    if ({cursor_pos, cursor_start, cursor_end, cursor_disable} !== '0) begin
      n_errors++;
      $display("FAIL cursor_preedge: cpos=%h cs=%h ce=%h cd=%b required all 0",
               cursor_pos, cursor_start, cursor_end, cursor_disable);
    end
    apply(IDL(1'b0));
    void'(sb.pop_front());
    n_checks++;
    if (cursor_pos !== 14'h1234 || cursor_start !== 5'h0B || cursor_end !== 5'h1F || cursor_disable !== 1'b1) begin
      n_errors++;
      $display("FAIL cursor_shadow: cpos=%h cs=%h ce=%h cd=%b required 1234/0b/1f/1",
               cursor_pos, cursor_start, cursor_end, cursor_disable);
    end
  endtask

  task automatic test_start_addr();
    op_t ops[$];
    logic [16:0] got, exp;
    do_reset();
    ops = '{W(OFF_INDEX, 2'b11, 16'hFF0C), R(OFF_INDEX, 2'b11, 16'h3F0C),
            W(OFF_INDEX, 2'b11, 16'h0A0C), W(OFF_INDEX, 2'b11, 16'hBC0D),
            R(OFF_INDEX, 2'b10, 16'hBC00), W(OFF_INDEX, 2'b01, 16'h000C),
            R(OFF_INDEX, 2'b10, 16'h0A00), IDL()};
    foreach (ops[i]) begin
      apply(ops[i]);
      got = {data_m_ack, data_m_data_out}; exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL start_bus[%0d]: ack/data=%b/%h required %b/%h", i, got[16], got[15:0], exp[16], exp[15:0]);
      end
    end
    @(negedge clk);
    data_m_access = 1'b0; vga_vsync = 1'b0;
    #1;
    n_checks++;
    if (start_addr !== 14'h0) begin
      n_errors++;
      $display("FAIL start_early: start_addr=%h required 0000", start_addr);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (start_addr !== 14'h0ABC) begin
      n_errors++;
      $display("FAIL start_edge: start_addr=%h required 0abc", start_addr);
    end
    // live write landing in the retrace-start cycle must wait for the next frame
    ops = '{IDL(1'b1), W(OFF_INDEX, 2'b10, 16'h0500, 1'b0)};
    foreach (ops[i]) begin
      apply(ops[i]);
      got = {data_m_ack, data_m_data_out}; exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL start_bus2[%0d]: ack/data=%b/%h required %b/%h", i, got[16], got[15:0], exp[16], exp[15:0]);
      end
    end
    n_checks++;
    if (start_addr !== 14'h0ABC) begin
      n_errors++;
      $display("FAIL start_coinc: start_addr=%h required 0abc", start_addr);
    end
    apply(IDL(1'b1)); void'(sb.pop_front());
    apply(IDL(1'b0)); void'(sb.pop_front());
    n_checks++;
    if (start_addr !== 14'h05BC) begin
      n_errors++;
      $display("FAIL start_next: start_addr=%h required 05bc", start_addr);
    end
  endtask

  task automatic test_status();
    op_t ops[$];
    logic [16:0] got, exp;
    do_reset();
    ops = '{R(OFF_STATUS, 2'b01, 16'h0000), R(OFF_STATUS, 2'b01, 16'h0001, 1'b1, 1'b0),
            R(OFF_STATUS, 2'b10, 16'h0000), IDL(1'b0),
            R(OFF_STATUS, 2'b01, 16'h0089, 1'b0), R(OFF_STATUS, 2'b01, 16'h0009, 1'b0),
            IDL(1'b1), R(OFF_STATUS, 2'b11, 16'h0000)};
    foreach (ops[i]) begin
      apply(ops[i]);
      got = {data_m_ack, data_m_data_out}; exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL status[%0d]: ack/data=%b/%h required %b/%h", i, got[16], got[15:0], exp[16], exp[15:0]);
      end
    end
  endtask

  task automatic test_status_coincident();
    op_t ops[$];
    logic [16:0] got, exp;
    do_reset();
    ops = '{IDL(1'b1), R(OFF_STATUS, 2'b01, 16'h0009, 1'b0),
            R(OFF_STATUS, 2'b01, 16'h0089, 1'b0), R(OFF_STATUS, 2'b01, 16'h0009, 1'b0),
            IDL(1'b1)};
    foreach (ops[i]) begin
      apply(ops[i]);
      got = {data_m_ack, data_m_data_out}; exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL status_coinc[%0d]: ack/data=%b/%h required %b/%h", i, got[16], got[15:0], exp[16], exp[15:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    op_t ops[$];
    logic [16:0] got, exp;
    do_reset();
    ops = '{W(OFF_INDEX, 2'b11, 16'hFF1F), R(OFF_INDEX, 2'b10, 16'h0000),
            R(OFF_INDEX, 2'b01, 16'h001F), W(OFF_INDEX, 2'b11, 16'h5510),
            R(OFF_INDEX, 2'b11, 16'h0010), R(3'b000, 2'b11, 16'h0000),
            R(3'b111, 2'b11, 16'h0000), W(OFF_MODE, 2'b11, 16'hA55A),
            R(OFF_MODE, 2'b11, 16'hA55A), W(OFF_MODE, 2'b01, 16'h1234),
            R(OFF_MODE, 2'b11, 16'hA534), W(3'b100, 2'b11, 16'hFFFF),
            NOCS(1'b1, OFF_MODE, 16'h0000), NOCS(1'b0, OFF_MODE, 16'h0000),
            R(OFF_MODE, 2'b10, 16'hA500), IDL()};
    foreach (ops[i]) begin
      apply(ops[i]);
      got = {data_m_ack, data_m_data_out}; exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL b2b[%0d]: ack/data=%b/%h required %b/%h", i, got[16], got[15:0], exp[16], exp[15:0]);
      end
    end
    n_checks++;
    if (mode_reg !== 8'h34 || colour_reg !== 8'hA5) begin
      n_errors++;
      $display("FAIL mode_colour: mode=%h colour=%h required 34/a5", mode_reg, colour_reg);
    end
  endtask

  task automatic test_irq();
    logic [16:0] got, exp;
    do_reset();
    apply(W(OFF_MODE, 2'b01, 16'h0040)); void'(sb.pop_front());
    apply(IDL(1'b1)); void'(sb.pop_front());
    apply(IDL(1'b0)); void'(sb.pop_front());
`ifdef VGA_IRQ_EN
    for (int k = 0; k < 2 && vga_irq !== 1'b1; k++) begin
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (vga_irq !== 1'b1) begin
      n_errors++;
      $display("FAIL irq_assert: vga_irq=%b required 1 within 2 cycles", vga_irq);
    end
`else
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (vga_irq !== 1'b0) begin
      n_errors++;
      $display("FAIL irq_off: vga_irq=%b required 0", vga_irq);
    end
`endif
    apply(R(OFF_STATUS, 2'b01, 16'h0089, 1'b0));
    got = {data_m_ack, data_m_data_out}; exp = sb.pop_front(); n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL irq_status: ack/data=%b/%h required %b/%h", got[16], got[15:0], exp[16], exp[15:0]);
    end
    apply(IDL(1'b0)); void'(sb.pop_front());
    n_checks++;
    if (vga_irq !== 1'b0) begin
      n_errors++;
      $display("FAIL irq_clear: vga_irq=%b required 0", vga_irq);
    end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    apply(W(OFF_MODE, 2'b11, 16'h7740)); void'(sb.pop_front());
    apply(W(OFF_INDEX, 2'b11, 16'h2A0A)); void'(sb.pop_front());
    apply(IDL(1'b1)); void'(sb.pop_front());
    apply(IDL(1'b0)); void'(sb.pop_front());
    apply(IDL(1'b0)); void'(sb.pop_front());
    n_checks++;
    if (cursor_start !== 5'h0A || mode_reg !== 8'h40 || colour_reg !== 8'h77) begin
      n_errors++;
      $display("FAIL prereset: cs=%h mode=%h colour=%h required 0a/40/77", cursor_start, mode_reg, colour_reg);
    end
    @(negedge clk);
    reset = 1'b1; cs = 1'b1; data_m_access = 1'b1; data_m_wr_en = 1'b0;
    data_m_addr = {16'h0, OFF_MODE}; data_m_bytesel = 2'b11;
    @(posedge clk);
    #1;
    n_checks++;
    if (data_m_ack !== 1'b0 || data_m_data_out !== 16'h0) begin
      n_errors++;
      $display("FAIL reset_read: ack/data=%b/%h required 0/0000", data_m_ack, data_m_data_out);
    end
    n_checks++;
    if ({cursor_pos, start_addr, cursor_start, cursor_end, cursor_disable, mode_reg, colour_reg, vga_irq} !== '0) begin
      n_errors++;
      $display("FAIL reset_outs: cs=%h mode=%h colour=%h irq=%b required 0", cursor_start, mode_reg, colour_reg, vga_irq);
    end
    @(negedge clk);
    reset = 1'b0; data_m_access = 1'b0; vga_vsync = 1'b1;
  endtask

  initial begin
    reset = 1'b1; cs = 1'b0; data_m_access = 1'b0; data_m_wr_en = 1'b0;
    data_m_addr = '0; data_m_data_in = '0; data_m_bytesel = 2'b00;
    vga_vsync = 1'b1; vga_hsync = 1'b1;
    repeat (2) @(posedge clk);
    test_reset();
    test_cursor();
    test_start_addr();
    test_status();
    test_status_coincident();
    test_back_to_back();
    test_irq();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
